// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds op codes, FSM state codes, the divide-by-zero quotient and an op-class helper.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MUL   = 3'b000;
    localparam logic [2:0] MD_MULH  = 3'b001;
    localparam logic [2:0] MD_MULHU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_REM   = 3'b101;
    localparam logic [2:0] MD_REMU  = 3'b110;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [MD_XLEN-1:0] DIV_ZERO_Q = '1;

    // 3'b111 is folded into the multiply class (behaves as MUL).
    function automatic logic is_mul(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) ||
               (op == MD_MULHU) || (op == 3'b111);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, try to subtract.
// Ports: i_rem (partial remainder), i_msb (next dividend bit), i_divisor -> o_rem, o_qbit.
module muldiv_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_msb,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {i_rem, i_msb};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // Remainder stays below the divisor, so a clear top bit means no borrow.
    assign o_qbit  = ~w_diff[XLEN];
    assign o_rem   = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage iterative multiply/divide unit: IDLE->PREP->CALC->FIX->DONE.
// Ports: clk, rst (sync, active-high), start/op/a/b/rd_in request, flush squash;
// busy to hazard logic, done pulse with result/rd_out for bypass and writeback.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a one-shot product, skipping CALC.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN      = MD_XLEN,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    input  logic [ADDR_SIZE-1:0] rd_in,
    input  logic                 flush,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      result,
    output logic [ADDR_SIZE-1:0] rd_out
);

    localparam int CW = $clog2(XLEN + 1);

    logic [2:0]           r_state;
    logic [2:0]           r_op;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [ADDR_SIZE-1:0] r_rd;
    logic [XLEN-1:0]      r_opb;
    logic [2*XLEN-1:0]    r_acc;
    logic [XLEN-1:0]      r_rem;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_rneg;
    logic                 r_bzero;
    logic [XLEN-1:0]      r_result;
    logic [ADDR_SIZE-1:0] r_rd_out;

    logic              w_mul;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_drem;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remv;
    logic [XLEN-1:0]   w_fix;
    logic [CW-1:0]     w_cnt_nxt;

    assign w_mul = is_mul(r_op);
    assign w_sa  = r_a[XLEN-1] & is_signed_op(r_op);
    assign w_sb  = r_b[XLEN-1] & is_signed_op(r_op);
    assign w_ma  = w_sa ? -r_a : r_a;
    assign w_mb  = w_sb ? -r_b : r_b;

    // Shift-add: acc = {partial high, remaining multiplier bits}.
    assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                   (r_acc[0] ? {1'b0, r_opb} : '0);

    // Division reuses acc low half: dividend bits shift out, quotient bits shift in.
    muldiv_divstep #(.XLEN(XLEN)) u_divstep (
        .i_rem     (r_rem),
        .i_msb     (r_acc[XLEN-1]),
        .i_divisor (r_opb),
        .o_rem     (w_drem),
        .o_qbit    (w_qbit)
    );

    assign w_cnt_nxt = r_cnt - 1'b1;
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_quot    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_remv    = r_rneg ? -r_rem : r_rem;

    // Zero divisor bypasses the datapath: quotient all ones, remainder = a.
    always_comb begin
        w_fix = w_prod[XLEN-1:0];
        case (r_op)
            MD_MULH, MD_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:   w_fix = r_bzero ? DIV_ZERO_Q[XLEN-1:0] : w_quot;
            MD_REM, MD_REMU:   w_fix = r_bzero ? r_a : w_remv;
            default:           w_fix = w_prod[XLEN-1:0];
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fprod;
    assign w_fprod = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_op     <= MD_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_bzero  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b     <= b;
                        r_rd    <= rd_in;
                        r_state <= ST_PREP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    r_neg   <= w_sa ^ w_sb;
                    r_rneg  <= w_sa;
                    r_bzero <= (r_b == '0);
                    r_rem   <= '0;
                    r_cnt   <= CW'(XLEN);
                    r_state <= ST_CALC;
                    if (w_mul) begin
                        r_opb <= w_ma;
                        r_acc <= {{XLEN{1'b0}}, w_mb};
`ifdef MULDIV_FAST_MUL_EN
                        r_acc   <= w_fprod;
                        r_state <= ST_FIX;
`endif
                    end else begin
                        r_opb <= w_mb;
                        r_acc <= {{XLEN{1'b0}}, w_ma};
                    end
                end
                ST_CALC: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_mul) begin
                        r_acc <= {w_sum, r_acc[XLEN-1:1]};
                    end else begin
                        r_rem             <= w_drem;
                        r_acc[XLEN-1:0]   <= {r_acc[XLEN-2:0], w_qbit};
                    end
                    if (w_cnt_nxt == '0) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= w_fix;
                    r_rd_out <= r_rd;
                    r_state  <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == ST_PREP) || (r_state == ST_CALC) ||
                    (r_state == ST_FIX);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vectors, random ops vs a
// plain-arithmetic reference, flush, busy-start, back-to-back and reset cases.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv #(.XLEN(32), .ADDR_SIZE(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        logic [63:0]     t;
        case (o)
            MD_MULH:  t = sx * sy;
            MD_MULHU: t = ux * uy;
            MD_DIV: begin
                if (y == 0) t = 64'hFFFFFFFF;
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) t = {32'd0, x};
                else t = sx / sy;
            end
            MD_DIVU:  t = (y == 0) ? 64'hFFFFFFFF : ux / uy;
            MD_REM: begin
                if (y == 0) t = {32'd0, x};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) t = 0;
                else t = sx % sy;
            end
            MD_REMU:  t = (y == 0) ? {32'd0, x} : ux % uy;
            default:  t = ux * uy;
        endcase
        if (o == MD_MULH || o == MD_MULHU) return t[63:32];
        return t[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (o <= MD_MULHU || o == 3'b111) return 3;
`endif
        return 35;
    endfunction

    // Drives one request and measures it; callers do the comparisons.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t,
                         output int lat, output int bcnt,
                         output logic [31:0] res, output logic [4:0] rdo);
        @(negedge clk);
        op = o; a = x; b = y; rd_in = t; start = 1'b1;
        @(posedge clk);
        lat = -1; bcnt = 0; res = 'x; rdo = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n; res = result; rdo = rd_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        n_tests++;
        if ({result, rd_out} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_out: got %h/%0d want 0/0", result, rd_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op [14] = '{MD_MULHU, MD_MUL, MD_DIV, MD_REM, MD_DIVU,
                                   MD_REMU, MD_DIVU, MD_REM, MD_DIV, MD_REM,
                                   MD_MUL, MD_DIVU, MD_MULH, 3'b111};
        logic [31:0] t_a [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                  32'hFFFFFFF9, 32'd100, 32'd100, 32'h1234,
                                  32'h1234, 32'h80000000, 32'h80000000,
                                  32'd6, 32'd42, 32'hFFFFFFFE, 32'd5};
        logic [31:0] t_b [14] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd7, 32'd6, 32'd3, 32'd6};
        logic [31:0] t_e [14] = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD,
                                  32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF,
                                  32'h1234, 32'h80000000, 32'd0, 32'd42,
                                  32'd7, 32'hFFFFFFFF, 32'd30};
        int lat, bcnt;
        logic [31:0] res;
        logic [4:0]  rdo;
        for (int i = 0; i < 14; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 5'(i + 7), lat, bcnt, res, rdo);
            n_tests++;
            if (res !== t_e[i] || rdo !== 5'(i + 7)) begin
                n_fail++;
                $display("FAIL dir%0d_result: got %h/%0d want %h/%0d",
                         i, res, rdo, t_e[i], i + 7);
            end
            n_tests++;
            if (lat != exp_lat(t_op[i]) || bcnt != exp_lat(t_op[i]) - 1) begin
                n_fail++;
                $display("FAIL dir%0d_timing: got lat=%0d busy=%0d want %0d/%0d",
                         i, lat, bcnt, exp_lat(t_op[i]), exp_lat(t_op[i]) - 1);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] sp [4] = '{32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd1};
        logic [2:0]  o;
        logic [31:0] x, y, e, res;
        logic [4:0]  t, rdo;
        int lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 31);
            t = 5'($urandom);
            e = ref_model(o, x, y);
            do_op(o, x, y, t, lat, bcnt, res, rdo);
            n_tests++;
            if (res !== e || rdo !== t || lat != exp_lat(o)) begin
                n_fail++;
                $display("FAIL rnd%0d op=%0d a=%h b=%h: got %h/%0d lat=%0d want %h/%0d lat=%0d",
                         i, o, x, y, res, rdo, lat, e, t, exp_lat(o));
            end
        end
    endtask

    task automatic test_flush();
        int lat, bcnt, nd;
        logic [31:0] res;
        logic [4:0]  rdo;
        do_op(MD_DIVU, 32'd100, 32'd7, 5'd3, lat, bcnt, res, rdo);
        n_tests++;
        if (res !== 32'd14) begin
            n_fail++;
            $display("FAIL flush_setup: got %h want %h", res, 32'd14);
        end
        @(negedge clk);
        op = MD_DIV; a = 32'd999; b = 32'd3; rd_in = 5'd20; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got %b want 0", busy);
        end
        nd = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_tests++;
        if (nd != 0 || result !== 32'd14 || rd_out !== 5'd3) begin
            n_fail++;
            $display("FAIL flush_hold: got dones=%0d %h/%0d want 0 %h/3",
                     nd, result, rd_out, 32'd14);
        end
    endtask

    task automatic test_busy_start();
        int nd, first;
        logic [31:0] res;
        logic [4:0]  rdo;
        @(negedge clk);
        op = MD_DIVU; a = 32'd1000; b = 32'd10; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        nd = 0; first = -1; res = 'x; rdo = 'x;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) begin
                op = MD_MUL; a = 32'd2; b = 32'd2; rd_in = 5'd1; start = 1'b1;
            end
            if (done) begin
                nd++;
                if (first < 0) begin
                    first = n; res = result; rdo = rd_out;
                end
            end
        end
        n_tests++;
        if (nd != 1 || first != 35) begin
            n_fail++;
            $display("FAIL busy_start_done: got dones=%0d at %0d want 1 at 35", nd, first);
        end
        n_tests++;
        if (res !== 32'd100 || rdo !== 5'd9) begin
            n_fail++;
            $display("FAIL busy_start_res: got %h/%0d want %h/9", res, rdo, 32'd100);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [31:0] r1, r2;
        logic [4:0]  d2;
        @(negedge clk);
        op = MD_MUL; a = 32'd7; b = 32'd9; rd_in = 5'd4; start = 1'b1;
        @(posedge clk);
        t1 = -1; t2 = -1; r1 = 'x; r2 = 'x; d2 = 'x;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (t1 >= 0 && n == t1 + 1) start = 1'b0;
            if (done && t1 < 0) begin
                t1 = n; r1 = result;
                a = 32'd3; b = 32'd5; rd_in = 5'd5;
            end else if (done && t2 < 0) begin
                t2 = n; r2 = result; d2 = rd_out;
                break;
            end
        end
        start = 1'b0;
        n_tests++;
        if (r1 !== 32'd63 || t1 != exp_lat(MD_MUL)) begin
            n_fail++;
            $display("FAIL b2b_first: got %h at %0d want %h at %0d",
                     r1, t1, 32'd63, exp_lat(MD_MUL));
        end
        n_tests++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != exp_lat(MD_MUL)) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d want %0d", t2 - t1, exp_lat(MD_MUL));
        end
        n_tests++;
        if (r2 !== 32'd15 || d2 !== 5'd5) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%0d want %h/5", r2, d2, 32'd15);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op = MD_DIV; a = 32'd500; b = 32'd5; rd_in = 5'd11; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done, result, rd_out} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b %h/%0d want all 0",
                     busy, done, result, rd_out);
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_discard: got done=%b %h want 0 0", done, result);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0; rd_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
